// File: rtl/bin2bcd.sv
// Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
// It performs one step per clock and produces four decimal digits for inputs up to 13 bits wide.
module bin2bcd #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         ready,
  output logic         done_tick,
  output logic [3:0]   bcd3,
  output logic [3:0]   bcd2,
  output logic [3:0]   bcd1,
  output logic [3:0]   bcd0
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

  state_t          state_reg;
  logic [W-1:0]    bin_reg;
  logic [15:0]     dig_reg;
  logic [CW-1:0]   cnt_reg;
  logic            done_reg;
  logic [15:0]     bcd_reg;

  logic [15:0]     dig_adj;
  logic [W+15:0]   shift_next;

  // Correct each digit before the shift so that it carries correctly into the next decade.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign dig_adj[4*gi +: 4] = (dig_reg[4*gi +: 4] >= 4'd5) ?
                                  dig_reg[4*gi +: 4] + 4'd3 : dig_reg[4*gi +: 4];
    end
  endgenerate

  // Digits and operand shift together, so the operand MSB moves into the units digit LSB.
  assign shift_next = {dig_adj, bin_reg} << 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      bin_reg   <= '0;
      dig_reg   <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      bcd_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            bin_reg   <= bin;
            dig_reg   <= '0;
            cnt_reg   <= CW'(W);
            state_reg <= OP;
          end
        end
        OP: begin
          bin_reg <= shift_next[W-1:0];
          dig_reg <= shift_next[W +: 16];
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            bcd_reg   <= shift_next[W +: 16];
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ready     = (state_reg == IDLE);
  assign done_tick = done_reg;
  assign bcd3      = bcd_reg[15:12];
  assign bcd2      = bcd_reg[11:8];
  assign bcd1      = bcd_reg[7:4];
  assign bcd0      = bcd_reg[3:0];

endmodule

// File: tb/tb_bin2bcd.sv
// Scoreboard bench for bin2bcd: expected digits are queued on each accepted start and compared on done_tick.
// It also checks timing, that done_tick is one cycle wide, that results hold during OP, and reset behaviour.
module tb_bin2bcd;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] bin;
  logic         ready;
  logic         done_tick;
  logic [3:0]   bcd3, bcd2, bcd1, bcd0;
  logic [15:0]  bcd_all;

  int checks = 0;
  int errors = 0;

  bin2bcd #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bin       (bin),
    .ready     (ready),
    .done_tick (done_tick),
    .bcd3      (bcd3),
    .bcd2      (bcd2),
    .bcd1      (bcd1),
    .bcd0      (bcd0)
  );

  always #5 clk = ~clk;

  assign bcd_all = {bcd3, bcd2, bcd1, bcd0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Decimal reference written with division, not with double-dabble.
  function automatic logic [15:0] ref_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  logic [15:0] exp_q[$];
  int          cyc = 0;
  int          acc_cyc = 0;
  int          acc_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      exp_q.delete();
    end else if (start && ready) begin
      exp_q.push_back(ref_bcd(int'(bin)));
      acc_cyc <= cyc + 1;
      acc_cnt <= acc_cnt + 1;
    end
  end

  logic [15:0] last_result = '0;
  logic        prev_done = 1'b0;
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      last_result <= '0;
      prev_done   <= 1'b0;
    end else begin
      if (done_tick) begin
        done_cnt <= done_cnt + 1;
        check("done_width", 32'(prev_done), 0);
        check("latency", cyc - acc_cyc, W);
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'(done_tick), 0);
        end else begin
          $display("conv cycle %0d result %h expected %h", cyc, bcd_all, exp_q[0]);
          check("result", 32'(bcd_all), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
        last_result <= bcd_all;
      end else if (!ready) begin
        check("hold_in_op", 32'(bcd_all), 32'(last_result));
      end
      prev_done <= done_tick;
    end
  end

  // Called at a negedge with ready=1; returns the number of negedges that saw ready low.
  task automatic convert(input int v, output int n);
    bin   = W'(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!ready && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n, d0, a0, c1, k;
    int vals[$];

    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 1);
    check("rst_done", 32'(done_tick), 0);
    check("rst_bcd", 32'(bcd_all), 0);
    #2 reset = 1'b0;
    @(negedge clk);

    // Zero operand still takes all W steps.
    d0 = done_cnt;
    convert(0, n);
    check("ready_low_zero", n, W + 1);
    check("dones_zero", done_cnt - d0, 1);

    d0 = done_cnt;
    convert(1023, n);
    check("ready_low_max", n, W + 1);
    check("dones_max", done_cnt - d0, 1);

    // Start held high: the second request must land exactly two cycles after the result.
    d0 = done_cnt;
    a0 = acc_cnt;
    c1 = 0;
    k  = 0;
    bin   = W'(610);
    start = 1'b1;
    while (acc_cnt < a0 + 2 && k < 40) begin
      @(negedge clk);
      k++;
      if (acc_cnt == a0 + 1) c1 = acc_cyc;
    end
    start = 1'b0;
    check("b2b_gap", acc_cyc - c1, W + 2);
    check("b2b_dones_first", done_cnt - d0, 1);
    k = 0;
    while (!ready && k < 40) begin
      k++;
      @(negedge clk);
    end
    check("b2b_dones_total", done_cnt - d0, 2);

    // Operand change and start pulse during OP are ignored.
    d0 = done_cnt;
    a0 = acc_cnt;
    bin   = W'(999);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    bin   = W'(5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!ready && k < 40) begin
      k++;
      @(negedge clk);
    end
    check("ignore_accepts", acc_cnt - a0, 1);
    check("ignore_dones", done_cnt - d0, 1);

    // Reset in the middle of a conversion abandons it.
    d0 = done_cnt;
    bin   = W'(1023);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_ready", 32'(ready), 1);
    check("midrst_done", 32'(done_tick), 0);
    check("midrst_bcd", 32'(bcd_all), 0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_bcd_hold", 32'(bcd_all), 0);
    convert(55, n);
    check("ready_low_55", n, W + 1);

    // Sweep: digit boundaries followed by random operands.
    vals = '{1, 9, 10, 99, 100, 512, 999, 1000, 1022};
    for (int i = 0; i < 40; i++) vals.push_back($urandom_range(0, 1023));
    foreach (vals[i]) begin
      convert(vals[i], n);
      check("ready_low_sweep", n, W + 1);
    end

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
